imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 5-stage pipelined MIPS core. It owns the program counter, drives the word-addressed instruction memory's byte address input, and loads the IF/ID pipeline register. It applies hazard-unit stalls and branch/jump redirects, which flush IF/ID. It halts cleanly when fetch would leave the populated memory range, so an undefined (x) memory word is never latched.

Parameters:
IMEM_WORDS, 16, number of valid instruction words; byte addresses 0 .. 4*IMEM_WORDS-4 are fetchable
RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned
NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush, halt and reset (sll $0,$0,0)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  hazard-unit stall; hold PC and IF/ID
redirect_i  input  1  branch/jump taken, resolved in a later stage
redirect_pc_i  input  32  byte target address for redirect
imem_addr_o  output  32  byte address to instruction memory (= pc_o, combinational)
imem_data_i  input  32  instruction word returned combinationally by memory
if_id_instr_o  output  32  IF/ID instruction register
if_id_pc4_o  output  32  IF/ID PC+4 register
if_id_valid_o  output  1  IF/ID contents are a real fetched instruction
pc_o  output  32  current PC register
halted_o  output  1  high while in HALT state
fetch_count_o  output  16  count of instructions fetched into IF/ID, saturating

Behaviour:
- Reset (rst=1 at a clock edge, overrides every other input):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
- imem_addr_o = pc_o, combinational, no latency. Memory read is combinational, so the fetch registered into IF/ID appears one cycle after the PC value.
- in_range(a) = (a[1:0]==0) && (a>>2) < IMEM_WORDS.
- State RUN, evaluated per edge in priority order:
  1. redirect_i=1 (wins over stall_i): IF/ID flushed (instr=NOP_INSTR, valid=0, pc4 held). If in_range(redirect_pc_i), pc<=redirect_pc_i. Otherwise pc<=redirect_pc_i and state<=HALT. fetch_count unchanged.
  2. stall_i=1: pc, IF/ID and fetch_count all hold.
  3. Otherwise, if in_range(pc): if_id_instr<=imem_data_i, if_id_pc4<=pc+4, valid<=1, pc<=pc+4, fetch_count<=fetch_count+1 (saturates at 16'hFFFF). If pc is not in range: IF/ID flushed to NOP/valid=0, state<=HALT, pc held.
- State HALT:
  - halted_o=1; pc held; IF/ID holds NOP with valid=0; stall_i ignored.
  - redirect_i=1 with in_range(redirect_pc_i): pc<=redirect_pc_i, state<=RUN, halted_o falls on the same edge.
  - Redirect to an out-of-range target: pc updates, state stays HALT.
- PC arithmetic is 32-bit modulo. The range check always precedes use, so a wrapped value is never fetched.
- imem_data_i is sampled only when in_range(pc) is true, so an x word from an out-of-range read never enters IF/ID.
- Reset mid-stall, mid-redirect or in HALT returns to the reset values on that edge; any pending redirect is discarded.

Test Plan:
All scenarios use a bench memory model with IMEM_WORDS=6 loaded with 01897020, 01C96020, 01CE5820, 012A7822, 03197822, 01F8C820.
1. rst for 2 cycles, then run -> fetch sequence:
   - 1st edge: if_id_instr=01897020, pc4=4, valid=1, pc_o=4.
   - After 6 edges: if_id_instr=01F8C820, pc_o=24, fetch_count=6.
   - 7th edge: halted_o=1, valid=0, instr=00000000, pc_o=24.
2. Stall at pc=8 for 3 cycles (IF/ID holds 01C96020) -> IF/ID, pc_o=8 and fetch_count=2 constant throughout; first edge after release loads 01CE5820, pc_o=12.
3. redirect_i=1, target=4, with stall_i=1 at pc=16 -> next edge: valid=0, instr=NOP, pc_o=4; following edge: instr=01C96020, pc4=8.
4. Redirect to 32'h0000_0006 (misaligned) -> halted_o=1, pc_o=6. Then redirect to 0 -> halted_o=0; next edge fetches 01897020.
5. rst asserted during a stall at pc=12 with redirect_i=1 -> pc_o=0, valid=0, fetch_count=0, halted_o=0 on that edge.
6. Force fetch_count to 16'hFFFF (small-memory loop via repeated redirect to 0, or bench force) -> stays FFFF on further fetches.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer feeding IF/ID with stall, redirect flush and out-of-range halt
module imem_fetch_ctrl #(
  parameter int          IMEM_WORDS = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic [15:0] fetch_count_o
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, instr, instr_n, pc4, pc4_n;
  logic        valid, valid_n, pc_ok, rd_ok;
  logic [15:0] cnt, cnt_n;
  function automatic logic in_range(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(IMEM_WORDS));
  endfunction
  assign pc_ok         = in_range(pc);
  assign rd_ok         = in_range(redirect_pc_i);
  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign if_id_instr_o = instr;
  assign if_id_pc4_o   = pc4;
  assign if_id_valid_o = valid;
  assign halted_o      = state == HALT;
  assign fetch_count_o = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
      valid <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
      pc4   <= pc4_n;
      valid <= valid_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    pc4_n   = pc4;
    valid_n = valid;
    cnt_n   = cnt;
    if (redirect_i) begin
      pc_n    = redirect_pc_i;
      state_n = rd_ok ? RUN : HALT;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end else if (state == RUN && !stall_i) begin
      instr_n = pc_ok ? imem_data_i : NOP_INSTR;
      valid_n = pc_ok;
      pc4_n   = pc_ok ? pc + 32'd4 : pc4;
      pc_n    = pc_ok ? pc + 32'd4 : pc;
      cnt_n   = (pc_ok && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
      state_n = pc_ok ? RUN : HALT;
    end
  end
endmodule
